// File: rtl/spi_pkg.sv
// Shared SPI definitions: frame width default, slave FSM states, bus idle levels
// and the chip-select codes the master drives.
package spi_pkg;

  localparam int unsigned SPI_DATA_WIDTH = 8;

  typedef enum logic {IDLE, SHIFT} spi_state_e;

  localparam logic SCLK_IDLE = 1'b0;
  localparam logic CS_IDLE   = 1'b1;
  localparam logic MOSI_IDLE = 1'b0;

  localparam logic [2:0] CS_SEL0 = 3'b011;
  localparam logic [2:0] CS_SEL1 = 3'b101;
  localparam logic [2:0] CS_SEL2 = 3'b110;
  localparam logic [2:0] CS_NONE = 3'b111;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage input synchroniser with registered single-cycle rise/fall detects.
module spi_sync_edge #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] stg;
  logic              prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      stg  <= {STAGES{RESET_VAL}};
      prev <= RESET_VAL;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      stg  <= {stg[STAGES-2:0], din};
      prev <= stg[STAGES-1];
      rise <= stg[STAGES-1] & ~prev;
      fall <= ~stg[STAGES-1] & prev;
    end
  end

  assign sync = stg[STAGES-1];

endmodule

// File: rtl/spi_slave_if.sv
// SPI mode-0, LSB-first slave endpoint: oversampled bus, parallel RX byte with
// valid strobe, single-entry TX buffer serialised onto MISO.
module spi_slave_if import spi_pkg::*; #(
  parameter int unsigned           DATA_WIDTH  = SPI_DATA_WIDTH,
  parameter int unsigned           SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] IDLE_BYTE   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  SCLK,
  input  logic                  CS,
  input  logic                  MOSI,
  output logic                  MISO,
  input  logic [DATA_WIDTH-1:0] slaveDataToSend,
  input  logic                  txLoad,
  output logic                  txReady,
  output logic [DATA_WIDTH-1:0] slaveDataReceived,
  output logic                  rxValid,
  output logic                  frameAbort
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  logic sclk_rise, sclk_fall, sclk_level_unused;
  logic cs_s, cs_rise, cs_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(SCLK_IDLE)) u_sclk_sync (
    .clk(clk), .reset(reset), .din(SCLK),
    .sync(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(CS_IDLE)) u_cs_sync (
    .clk(clk), .reset(reset), .din(CS),
    .sync(cs_s), .rise(cs_rise), .fall(cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(MOSI_IDLE)) u_mosi_sync (
    .clk(clk), .reset(reset), .din(MOSI),
    .sync(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  spi_state_e            state, state_d;
  logic [DATA_WIDTH-1:0] tx_buf, tx_buf_d, tx_shift, tx_shift_d, rx_shift, rx_shift_d;
  logic [DATA_WIDTH-1:0] rx_data_d;
  logic [CNT_W-1:0]      bit_count, bit_count_d;
  logic                  tx_full, tx_full_d, miso_d, rx_valid_d, abort_d;
  logic                  consume, accept;

  // Next-state, shift datapath and TX buffer bookkeeping
  always_comb begin
    state_d     = state;
    tx_shift_d  = tx_shift;
    rx_shift_d  = rx_shift;
    bit_count_d = bit_count;
    miso_d      = MISO;
    rx_data_d   = slaveDataReceived;
    rx_valid_d  = 1'b0;
    abort_d     = 1'b0;
    consume     = 1'b0;

    case (state)
      IDLE: begin
        miso_d      = 1'b0;
        bit_count_d = '0;
        if (cs_fall) begin
          consume    = tx_full;
          tx_shift_d = tx_full ? tx_buf : IDLE_BYTE;
          miso_d     = tx_shift_d[0];
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_count == CNT_FULL) begin
          // Completion wins over a CS rise seen alongside the final SCLK rise
          rx_data_d   = rx_shift;
          rx_valid_d  = 1'b1;
          bit_count_d = '0;
          consume     = tx_full;
          tx_shift_d  = tx_full ? tx_buf : IDLE_BYTE;
          if (cs_s) begin
            miso_d  = 1'b0;
            state_d = IDLE;
          end
        end else if (cs_rise && !(sclk_rise && bit_count == CNT_LAST)) begin
          abort_d     = (bit_count != '0);
          bit_count_d = '0;
          miso_d      = 1'b0;
          state_d     = IDLE;
        end else if (sclk_rise) begin
          rx_shift_d  = {mosi_s, rx_shift[DATA_WIDTH-1:1]};
          bit_count_d = bit_count + CNT_W'(1);
        end else if (sclk_fall) begin
          if (bit_count != '0) begin
            tx_shift_d = tx_shift >> 1;
            miso_d     = tx_shift[1];
          end else begin
            miso_d = tx_shift[0];
          end
        end
      end
      default: state_d = IDLE;
    endcase

    accept    = txLoad && (!tx_full || consume);
    tx_full_d = accept | (tx_full & ~consume);
    tx_buf_d  = accept ? slaveDataToSend : tx_buf;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      tx_buf            <= '0;
      tx_full           <= 1'b0;
      tx_shift          <= '0;
      rx_shift          <= '0;
      bit_count         <= '0;
      MISO              <= 1'b0;
      slaveDataReceived <= '0;
      rxValid           <= 1'b0;
      frameAbort        <= 1'b0;
      txReady           <= 1'b1;
    end else begin
      state             <= state_d;
      tx_buf            <= tx_buf_d;
      tx_full           <= tx_full_d;
      tx_shift          <= tx_shift_d;
      rx_shift          <= rx_shift_d;
      bit_count         <= bit_count_d;
      MISO              <= miso_d;
      slaveDataReceived <= rx_data_d;
      rxValid           <= rx_valid_d;
      frameAbort        <= abort_d;
      txReady           <= ~tx_full_d;
    end
  end

endmodule

// File: tb/tb_spi_slave_if.sv
// Bench for spi_slave_if: acts as a mode-0 LSB-first master at clk/8 and
// scoreboards received bytes and MISO bytes against queued expectations.
module tb_spi_slave_if;

  logic       clk = 1'b0;
  logic       reset, SCLK, CS, MOSI, MISO;
  logic       txLoad, txReady, rxValid, frameAbort;
  logic [7:0] slaveDataToSend, slaveDataReceived;

  int checks = 0, errors = 0;
  int cyc = 0, rx_cnt = 0, abort_cnt = 0, rise_cyc = 0, rx_cyc = 0;
  int r0, a0;
  logic [7:0] m;
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_slave_if dut (
    .clk(clk), .reset(reset), .SCLK(SCLK), .CS(CS), .MOSI(MOSI), .MISO(MISO),
    .slaveDataToSend(slaveDataToSend), .txLoad(txLoad), .txReady(txReady),
    .slaveDataReceived(slaveDataReceived), .rxValid(rxValid), .frameAbort(frameAbort)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pop the RX scoreboard on every rxValid pulse; count abort pulses
  always @(negedge clk) begin
    if (rxValid === 1'b1) begin
      rx_cnt++;
      rx_cyc = cyc;
      if (rx_q.size() == 0) check("rx_unexpected", 32'(rxValid), 32'd0);
      else                  check("rx_data", 32'(slaveDataReceived), 32'(rx_q.pop_front()));
    end
    if (frameAbort === 1'b1) abort_cnt++;
  end

  task automatic load_tx(input logic [7:0] b);
    slaveDataToSend = b;
    txLoad = 1'b1;
    @(negedge clk);
    txLoad = 1'b0;
    @(negedge clk);
  endtask

  task automatic cs_low();
    CS = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic cs_high();
    CS = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic run_bits(input logic [7:0] mo, input int n, output logic [7:0] mi);
    mi = '0;
    for (int i = 0; i < n; i++) begin
      MOSI = mo[i];
      repeat (4) @(negedge clk);
      mi[i]    = MISO;
      SCLK     = 1'b1;
      rise_cyc = cyc;
      repeat (4) @(negedge clk);
      SCLK = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1; SCLK = 1'b0; CS = 1'b1; MOSI = 1'b0;
    txLoad = 1'b0; slaveDataToSend = '0;
    repeat (3) @(negedge clk);
    check("rst_miso", 32'(MISO), 32'd0);
    check("rst_rxdata", 32'(slaveDataReceived), 32'd0);
    check("rst_rxvalid", 32'(rxValid), 32'd0);
    check("rst_abort", 32'(frameAbort), 32'd0);
    check("rst_txready", 32'(txReady), 32'd1);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Plain receive of 0xA5 with empty TX buffer
    r0 = rx_cnt; a0 = abort_cnt;
    cs_low();
    tx_q.push_back(8'h00);
    rx_q.push_back(8'hA5);
    run_bits(8'hA5, 8, m);
    check("t1_miso", 32'(m), 32'(tx_q.pop_front()));
    cs_high();
    check("t1_rx_count", 32'(rx_cnt - r0), 32'd1);
    check("t1_abort", 32'(abort_cnt - a0), 32'd0);
    check("t1_latency", 32'(rx_cyc - rise_cyc), 32'd5);
    check("t1_rxdata_held", 32'(slaveDataReceived), 32'hA5);

    // Buffered TX byte 0x3C
    load_tx(8'h3C);
    tx_q.push_back(8'h3C);
    check("t2_txready_full", 32'(txReady), 32'd0);
    cs_low();
    check("t2_txready_consumed", 32'(txReady), 32'd1);
    rx_q.push_back(8'hC3);
    run_bits(8'hC3, 8, m);
    check("t2_miso", 32'(m), 32'(tx_q.pop_front()));
    cs_high();

    // Back-to-back frames with the buffer refilled mid-frame
    r0 = rx_cnt;
    load_tx(8'h81);
    tx_q.push_back(8'h81);
    cs_low();
    load_tx(8'h7E);
    tx_q.push_back(8'h7E);
    rx_q.push_back(8'h12);
    run_bits(8'h12, 8, m);
    check("t3_miso0", 32'(m), 32'(tx_q.pop_front()));
    rx_q.push_back(8'h34);
    run_bits(8'h34, 8, m);
    check("t3_miso1", 32'(m), 32'(tx_q.pop_front()));
    cs_high();
    check("t3_rx_count", 32'(rx_cnt - r0), 32'd2);
    check("t3_txready", 32'(txReady), 32'd1);

    // Abort after 5 rises, then a full 0xFF frame
    r0 = rx_cnt; a0 = abort_cnt;
    cs_low();
    run_bits(8'h1F, 5, m);
    cs_high();
    check("t4_abort_count", 32'(abort_cnt - a0), 32'd1);
    check("t4_rx_none", 32'(rx_cnt - r0), 32'd0);
    check("t4_rxdata_kept", 32'(slaveDataReceived), 32'h34);
    cs_low();
    tx_q.push_back(8'h00);
    rx_q.push_back(8'hFF);
    run_bits(8'hFF, 8, m);
    check("t4_miso", 32'(m), 32'(tx_q.pop_front()));
    cs_high();
    check("t4_rx_count", 32'(rx_cnt - r0), 32'd1);
    check("t4_abort_once", 32'(abort_cnt - a0), 32'd1);

    // Idle byte at CS fall; load while full is dropped
    cs_low();
    tx_q.push_back(8'h00);
    load_tx(8'h96);
    tx_q.push_back(8'h96);
    check("t5_txready_full", 32'(txReady), 32'd0);
    load_tx(8'h69);
    check("t5_txready_still_full", 32'(txReady), 32'd0);
    rx_q.push_back(8'h5C);
    run_bits(8'h5C, 8, m);
    check("t5_miso_idle", 32'(m), 32'(tx_q.pop_front()));
    rx_q.push_back(8'hC5);
    run_bits(8'hC5, 8, m);
    check("t5_miso_first_load", 32'(m), 32'(tx_q.pop_front()));
    cs_high();
    check("t5_txready_end", 32'(txReady), 32'd1);

    // Reset mid-frame after the 4th rise
    load_tx(8'hFF);
    cs_low();
    load_tx(8'hAA);
    r0 = rx_cnt; a0 = abort_cnt;
    run_bits(8'hE7, 4, m);
    reset = 1'b1;
    @(negedge clk);
    check("t6_miso", 32'(MISO), 32'd0);
    check("t6_rxdata", 32'(slaveDataReceived), 32'd0);
    check("t6_rxvalid", 32'(rxValid), 32'd0);
    check("t6_abort", 32'(frameAbort), 32'd0);
    check("t6_txready", 32'(txReady), 32'd1);
    CS = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    check("t6_no_rx_pulse", 32'(rx_cnt - r0), 32'd0);
    check("t6_no_abort_pulse", 32'(abort_cnt - a0), 32'd0);
    cs_low();
    tx_q.push_back(8'h00);
    rx_q.push_back(8'h5A);
    run_bits(8'h5A, 8, m);
    check("t6_miso", 32'(m), 32'(tx_q.pop_front()));
    cs_high();
    check("t6_rxdata_after", 32'(slaveDataReceived), 32'h5A);

    check("rx_queue_drained", 32'(rx_q.size()), 32'd0);
    check("tx_queue_drained", 32'(tx_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
